// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program-counter width, call-stack depth and the
// count-width helper used by the stack, the control unit and the PC logic.
package cpu_pkg;

  localparam int AW_DEF    = 10;
  localparam int DEPTH_DEF = 16;

  // Operation selected by the call/return strobes in one cycle
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_e;

  // Bits needed to hold an entry count from 0 to depth inclusive
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/subroutine_stack.sv
// Return-address stack for CALL/RET. q is the live top of stack so a return
// can select its target in the same cycle as the pop.
// Build option: define STACK_GUARD_EN to make push-on-full / pop-on-empty
// harmless and flag them (ovf/udf); otherwise the pointer wraps modulo DEPTH
// and the error flags are tied low.
module subroutine_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [AW-1:0]               d,
  output logic [AW-1:0]               q,
  output logic                        empty,
  output logic                        full,
  output logic [count_w(DEPTH)-1:0]   count,
  output logic                        ovf,
  output logic                        udf,
  input  logic                        clr_err
);

  localparam int CW = count_w(DEPTH);
  localparam int IW = $clog2(DEPTH);

  logic [CW-1:0] sp;
  logic [CW-1:0] sp_next;
  logic [AW-1:0] mem [DEPTH];
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic          ovf_set;
  logic          udf_set;
  stack_op_e     op;

  // Truncating to IW bits gives the modulo-DEPTH slot: sp=DEPTH maps to 0
  // and sp=0 maps to DEPTH-1 for the top slot.
  assign top_idx = IW'(sp - CW'(1));
  assign wr_idx  = IW'(sp);
  assign op      = stack_op_e'({push, pop});

  assign empty = (sp == '0);
  assign full  = (sp == CW'(DEPTH));
  assign count = sp;
  assign q     = empty ? '0 : mem[top_idx];

  // Decode the strobes into next pointer, memory write and error events
  always_comb begin
    sp_next = sp;
    wr_en   = 1'b0;
    wr_addr = wr_idx;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    case (op)
      OP_PUSH: begin
`ifdef STACK_GUARD_EN
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          sp_next = sp + CW'(1);
        end
`else
        wr_en   = 1'b1;
        sp_next = full ? CW'(1) : sp + CW'(1);
`endif
      end
      OP_POP: begin
`ifdef STACK_GUARD_EN
        if (empty) udf_set = 1'b1;
        else       sp_next = sp - CW'(1);
`else
        sp_next = empty ? CW'(DEPTH - 1) : sp - CW'(1);
`endif
      end
      OP_REPL: begin
        wr_addr = top_idx;
`ifdef STACK_GUARD_EN
        if (empty) udf_set = 1'b1;
        else       wr_en   = 1'b1;
`else
        wr_en = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Stack pointer; reset beats any strobe in the same cycle
  always_ff @(posedge clk) begin
    if (reset) sp <= '0;
    else       sp <= sp_next;
  end

  // Return-address storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_addr] <= d;
  end

`ifdef STACK_GUARD_EN
  // Sticky error flags: a new event in the clearing cycle keeps its flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (clr_err) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end
      if (ovf_set) ovf <= 1'b1;
      if (udf_set) udf <= 1'b1;
    end
  end
`else
  logic unused_err;
  assign unused_err = clr_err ^ ovf_set ^ udf_set;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_subroutine_stack.sv
// Self-checking bench for subroutine_stack (default DEPTH=16, AW=10).
module tb_subroutine_stack;

  localparam int DEPTH = 16;
  localparam int AW    = 10;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset, push, pop, clr_err;
  logic [AW-1:0] d;
  logic [AW-1:0] q;
  logic          empty, full, ovf, udf;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  // reference model: stack contents and number of entries
  int ref_mem [DEPTH];
  int ref_n;
  int ref_ovf, ref_udf;

  subroutine_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .d(d), .q(q),
    .empty(empty), .full(full), .count(count), .ovf(ovf), .udf(udf),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int ref_q();
    if (ref_n == 0) return 0;
    return ref_mem[(ref_n - 1 + DEPTH) % DEPTH];
  endfunction

  task automatic model_step(input bit p, input bit o, input bit c, input bit r, input int dv);
    if (r) begin
      ref_n = 0; ref_ovf = 0; ref_udf = 0;
      return;
    end
`ifdef STACK_GUARD_EN
    if (c) begin ref_ovf = 0; ref_udf = 0; end
    if (p && !o) begin
      if (ref_n == DEPTH) ref_ovf = 1;
      else begin ref_mem[ref_n] = dv; ref_n++; end
    end else if (!p && o) begin
      if (ref_n == 0) ref_udf = 1;
      else ref_n--;
    end else if (p && o) begin
      if (ref_n == 0) ref_udf = 1;
      else ref_mem[ref_n - 1] = dv;
    end
`else
    if (p && !o) begin
      ref_mem[ref_n % DEPTH] = dv;
      ref_n = ref_n % DEPTH + 1;
    end else if (!p && o) begin
      ref_n = (ref_n == 0) ? DEPTH - 1 : ref_n - 1;
    end else if (p && o) begin
      ref_mem[(ref_n - 1 + DEPTH) % DEPTH] = dv;
    end
`endif
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    chk({name, ".q"},     int'(q),     ref_q());
    chk({name, ".count"}, int'(count), ref_n);
    chk({name, ".empty"}, int'(empty), int'(ref_n == 0));
    chk({name, ".full"},  int'(full),  int'(ref_n == DEPTH));
    chk({name, ".ovf"},   int'(ovf),   ref_ovf);
    chk({name, ".udf"},   int'(udf),   ref_udf);
  endtask

  // drive one cycle, advance the model, sample 1 time unit after the edge
  task automatic cycle(input bit p, input bit o, input bit c, input bit r, input int dv);
    push = p; pop = o; clr_err = c; reset = r; d = AW'(dv);
    model_step(p, o, c, r, dv);
    @(posedge clk);
    #1;
    push = 0; pop = 0; clr_err = 0; reset = 0;
  endtask

  typedef struct {
    bit p; bit o; int dv;
    int exp_q; int exp_count; bit exp_empty;
  } vec_t;

  vec_t vecs [8];

  initial begin
    push = 0; pop = 0; clr_err = 0; reset = 1; d = '0;
    ref_n = 0; ref_ovf = 0; ref_udf = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
    @(negedge clk);
    cycle(0, 0, 0, 1, 0);
    chk("reset.count", int'(count), 0);
    chk("reset.empty", int'(empty), 1);
    chk("reset.full",  int'(full),  0);
    chk("reset.q",     int'(q),     0);
    chk("reset.ovf",   int'(ovf),   0);
    chk("reset.udf",   int'(udf),   0);

    // basic call/return and top replacement, fixed expectations
    vecs[0] = '{1, 0, 'h005, 'h005, 1, 0};
    vecs[1] = '{1, 0, 'h123, 'h123, 2, 0};
    vecs[2] = '{0, 1, 'h000, 'h005, 1, 0};
    vecs[3] = '{0, 1, 'h000, 'h000, 0, 1};
    vecs[4] = '{1, 0, 'h040, 'h040, 1, 0};
    vecs[5] = '{1, 1, 'h080, 'h080, 1, 0};
    vecs[6] = '{0, 0, 'h3AA, 'h080, 1, 0};
    vecs[7] = '{0, 1, 'h000, 'h000, 0, 1};
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].p, vecs[i].o, 0, 0, vecs[i].dv);
      chk($sformatf("vec%0d.q", i),     int'(q),     vecs[i].exp_q);
      chk($sformatf("vec%0d.count", i), int'(count), vecs[i].exp_count);
      chk($sformatf("vec%0d.empty", i), int'(empty), int'(vecs[i].exp_empty));
    end

    // fill to full
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0, 'h010 + i);
    chk("fill.full",  int'(full),  1);
    chk("fill.q",     int'(q),     'h01F);
    chk("fill.count", int'(count), 16);

`ifdef STACK_GUARD_EN
    cycle(1, 0, 0, 0, 'h3FF);
    chk("ovf.flag",  int'(ovf),   1);
    chk("ovf.count", int'(count), 16);
    chk("ovf.q",     int'(q),     'h01F);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, 0, 0, 0);
      chk($sformatf("drain%0d.q", i), int'(q), (i == DEPTH - 1) ? 0 : 'h01E - i);
    end
    chk("drain.empty", int'(empty), 1);
    cycle(0, 1, 0, 0, 0);
    chk("udf.flag",  int'(udf),   1);
    chk("udf.count", int'(count), 0);
    cycle(0, 0, 1, 0, 0);
    chk("clr.ovf", int'(ovf), 0);
    chk("clr.udf", int'(udf), 0);
    cycle(1, 1, 1, 0, 'h111);
    chk("clr_vs_err.udf",   int'(udf),   1);
    chk("clr_vs_err.count", int'(count), 0);
    cycle(0, 0, 1, 0, 0);
`else
    cycle(1, 0, 0, 0, 'h3FF);
    chk("wrap.count", int'(count), 1);
    chk("wrap.q",     int'(q),     'h3FF);
    chk("wrap.ovf",   int'(ovf),   0);
    cycle(0, 1, 0, 0, 0);
    chk("wrap.empty", int'(empty), 1);
    cycle(0, 1, 0, 0, 0);
    chk("wrap_pop.count", int'(count), 15);
    chk("wrap_pop.q",     int'(q),     'h01E);
    chk("wrap_pop.udf",   int'(udf),   0);
`endif
    check_model("post_boundary");

    // reset beats push
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 'h200 + i);
    chk("three.count", int'(count), 3);
    cycle(1, 0, 1, 1, 'h155);
    chk("rst_push.count", int'(count), 0);
    chk("rst_push.empty", int'(empty), 1);
    chk("rst_push.q",     int'(q),     0);
    chk("rst_push.ovf",   int'(ovf),   0);
    chk("rst_push.udf",   int'(udf),   0);

    // randomized traffic against the model, with push-heavy and pop-heavy phases
    for (int i = 0; i < 2000; i++) begin
      int bias, r;
      bit p, o, c, rs;
      bias = ((i / 100) % 2 == 0) ? 70 : 30;
      r  = int'($urandom_range(0, 99));
      p  = (r < bias);
      o  = ($urandom_range(0, 99) < 100 - bias);
      c  = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 199) == 0);
      cycle(p, o, c, rs, int'($urandom_range(0, (1 << AW) - 1)));
      check_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subroutine_stack.md
SUBROUTINE_STACK -- requirements
Module: subroutine_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of return-address entries (power of two, 4..64).
REQ-002 The block SHALL have parameter AW, default 10, giving the width of a program-counter address.
REQ-003 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, is the reset; reset SHALL be synchronous and active-high.
REQ-005 Port push, input, 1, is the call strobe from the control unit.
REQ-006 Port pop, input, 1, is the return strobe from the control unit.
REQ-007 Port d, input, AW, is the return address to store, i.e. PC+1 of the call.
REQ-008 Port q, output, AW, is the current top-of-stack address feeding the PC source mux.
REQ-009 Port empty, output, 1, is high when the stack holds zero entries.
REQ-010 Port full, output, 1, is high when the stack holds DEPTH entries.
REQ-011 Port count, output, clog2(DEPTH+1), is the number of valid entries.
REQ-012 Port ovf, output, 1, is the sticky overflow flag.
REQ-013 Port udf, output, 1, is the sticky underflow flag.
REQ-014 Port clr_err, input, 1, clears ovf and udf.

Function
REQ-015 The stack SHALL be a LIFO of DEPTH x AW registers indexed by pointer sp, where sp equals count.
REQ-016 q SHALL be combinational: mem[sp-1] when not empty, all-zero when empty, so that a pop selects the return address in the same cycle.
REQ-017 Push only, not full: the block SHALL write mem[sp] <= d and set sp <= sp+1 at the next edge.
REQ-018 Pop only, not empty: the block SHALL set sp <= sp-1 at the next edge, with memory contents unchanged.
REQ-019 Push and pop together, not empty: the block SHALL write mem[sp-1] <= d (top replaced) and leave sp unchanged.
REQ-020 Neither strobe asserted: all state SHALL hold.
REQ-021 empty, full and count SHALL be combinational decodes of sp and SHALL reflect the state after the last edge.
REQ-022 Boundary behaviour (push on full, pop on empty, push and pop together on empty) SHALL be as defined under Configuration.
REQ-023 clr_err SHALL clear ovf and udf at the next edge; an error event in the same cycle SHALL win, leaving its flag set.

Reset
REQ-024 Reset SHALL set sp=0, giving count=0, empty=1, full=0, q=0, ovf=0 and udf=0.
REQ-025 Memory contents SHALL NOT be required to reset.
REQ-026 Reset SHALL override push, pop and clr_err in the same cycle.

Configuration
REQ-027 Macro STACK_GUARD_EN SHALL select the boundary behaviour.
REQ-028 With STACK_GUARD_EN defined:
- push on full SHALL be ignored and SHALL set ovf;
- pop on empty SHALL be ignored and SHALL set udf;
- push and pop together on empty SHALL write nothing and SHALL set udf.
REQ-029 With STACK_GUARD_EN undefined:
- sp SHALL wrap modulo DEPTH;
- push on full SHALL write mem[0] and set sp to 1;
- pop on empty SHALL set sp to DEPTH-1;
- ovf and udf SHALL be tied to 0 and clr_err SHALL be ignored.

Structure
REQ-030 AW default, DEPTH default and a function for the count width SHALL reside in shared package cpu_pkg, also used by the control unit and PC logic.
REQ-031 The block SHALL have no sub-module; register array and pointer logic SHALL stay in one module.

Verification
REQ-032 Reset, then push d=0x005, push d=0x123 -> count=2, q=0x123; pop -> q=0x005, count=1; pop -> empty=1, q=0.
REQ-033 Push 16 distinct values 0x010..0x01F -> full=1, q=0x01F; 16 pops -> q sequence 0x01F down to 0x010, then empty=1.
REQ-034 With guard, on full push d=0x3FF -> ovf=1, count=16, q unchanged; pop on empty -> udf=1; clr_err -> both flags 0 next cycle.
REQ-035 Without guard, on full push d=0x3FF -> count=1, q=0x3FF, ovf=0.
REQ-036 Holding 0x040, assert push and pop with d=0x080 -> count unchanged, q=0x080.
REQ-037 Reset asserted with push=1 after 3 entries -> count=0, empty=1, flags 0, no write.
